ulx3s_pll_reset_sequencer: RTL and testbench

Parametrised PLL supervisor and reset sequencer for ULX3S designs. It runs in the 25 MHz board-clock domain next to the EHXPLLL wrapper and synchronises and qualifies the PLL `LOCK` output. It releases `NCHAN` active-low domain resets in a staggered order and re-kicks the PLL through its `RST` pin if lock is not reached. Lock loss, software reset and lock timeout are all handled without a board reset.

---
 rtl/ulx3s_pll_reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ulx3s_pll_reset_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulx3s_pll_reset_sequencer.sv
//------------------------------------------------------------------------------
// Module : ulx3s_pll_reset_sequencer
// Brief  : ULX3S PLL lock supervisor with staggered per-domain reset release.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ulx3s_pll_reset_sequencer #(
  parameter int NCHAN       = 4,
  parameter int LOCK_STABLE = 1024,
  parameter int STAGGER     = 16,
  parameter int TIMEOUT     = 65536,
  parameter int KICK_LEN    = 8
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             pll_locked,
  input  logic             sw_reset,
  output logic             pll_rst,
  output logic [NCHAN-1:0] chan_rstn,
  output logic             ready,
  output logic [7:0]       relock_count,
  output logic [7:0]       kick_count
);

  localparam int C_STAB_W = $clog2(LOCK_STABLE) + 1;
  localparam int C_TO_W   = $clog2(TIMEOUT) + 1;
  localparam int C_STEP_W = $clog2(NCHAN * STAGGER) + 1;
  localparam int C_KICK_W = $clog2(KICK_LEN) + 1;

  localparam logic [C_STAB_W-1:0] C_STAB_LAST = C_STAB_W'(LOCK_STABLE - 1);
  localparam logic [C_TO_W-1:0]   C_TO_LAST   = C_TO_W'(TIMEOUT - 1);
  localparam logic [C_KICK_W-1:0] C_KICK_LAST = C_KICK_W'(KICK_LEN - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_KICK      = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_lk;
  logic [C_STAB_W-1:0] r_scnt;
  logic [C_TO_W-1:0]   r_tcnt;
  logic [C_STEP_W-1:0] r_step;
  logic [C_KICK_W-1:0] r_kcnt;
  logic                r_pll_rst;
  logic [NCHAN-1:0]    r_chan;
  logic                r_ready;
  logic [7:0]          r_relock_count;
  logic [7:0]          r_kick_count;

  logic [C_STEP_W-1:0] w_step_next;
  logic [NCHAN-1:0]    w_chan_due;
  logic                w_timeout;

  assign w_step_next = r_step + C_STEP_W'(1);
  assign w_timeout   = (r_tcnt == C_TO_LAST);

  // Channel i becomes due once the release step reaches (i+1)*STAGGER.
  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    localparam logic [C_STEP_W-1:0] C_AT = C_STEP_W'((i + 1) * STAGGER);
    assign w_chan_due[i] = (w_step_next >= C_AT);
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_WAIT_LOCK;
      r_sync1        <= 1'b0;
      r_lk           <= 1'b0;
      r_scnt         <= '0;
      r_tcnt         <= '0;
      r_step         <= '0;
      r_kcnt         <= '0;
      r_pll_rst      <= 1'b0;
      r_chan         <= '0;
      r_ready        <= 1'b0;
      r_relock_count <= '0;
      r_kick_count   <= '0;
    end else begin
      r_sync1 <= pll_locked;
      r_lk    <= r_sync1;
      case (r_state)
        S_WAIT_LOCK, S_STABLE: begin
          r_chan  <= '0;
          r_ready <= 1'b0;
          if (w_timeout) begin
            r_state      <= S_KICK;
            r_pll_rst    <= 1'b1;
            r_kcnt       <= '0;
            r_kick_count <= r_kick_count + {7'd0, (r_kick_count != 8'hFF)};
          end else begin
            r_tcnt <= r_tcnt + C_TO_W'(1);
            if (r_state == S_WAIT_LOCK) begin
              if (r_lk) begin
                r_state <= S_STABLE;
                r_scnt  <= '0;
              end
            end else if (!r_lk) begin
              r_state <= S_WAIT_LOCK;
            end else if (r_scnt == C_STAB_LAST) begin
              r_state <= S_RELEASE;
              r_step  <= '0;
              r_tcnt  <= '0;
            end else begin
              r_scnt <= r_scnt + C_STAB_W'(1);
            end
          end
        end
        S_RELEASE, S_RUN: begin
          // Lock loss takes priority over a software restart.
          if (!r_lk) begin
            r_state        <= S_WAIT_LOCK;
            r_chan         <= '0;
            r_ready        <= 1'b0;
            r_tcnt         <= '0;
            r_relock_count <= r_relock_count + {7'd0, (r_relock_count != 8'hFF)};
          end else if (sw_reset) begin
            r_state <= S_RELEASE;
            r_step  <= '0;
            r_chan  <= '0;
            r_ready <= 1'b0;
          end else if (r_state == S_RELEASE) begin
            r_step <= w_step_next;
            r_chan <= r_chan | w_chan_due;
            if (w_chan_due[NCHAN-1]) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end
          end
        end
        S_KICK: begin
          if (r_kcnt == C_KICK_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_tcnt    <= '0;
          end else begin
            r_kcnt <= r_kcnt + C_KICK_W'(1);
          end
        end
        default: begin
          r_state   <= S_WAIT_LOCK;
          r_pll_rst <= 1'b0;
          r_chan    <= '0;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst      = r_pll_rst;
  assign chan_rstn    = r_chan;
  assign ready        = r_ready;
  assign relock_count = r_relock_count;
  assign kick_count   = r_kick_count;

endmodule

`default_nettype wire

// File: tb/tb_ulx3s_pll_reset_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_ulx3s_pll_reset_sequencer
// Brief  : Scoreboard bench for the PLL reset sequencer with a timestamp model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ulx3s_pll_reset_sequencer;

  localparam int NCHAN       = 4;
  localparam int LOCK_STABLE = 16;
  localparam int STAGGER     = 4;
  localparam int TIMEOUT     = 64;
  localparam int KICK_LEN    = 8;

  localparam int M_WAIT = 0;
  localparam int M_REL  = 1;
  localparam int M_KICK = 2;

  logic             clkin = 1'b0;
  logic             resetn = 1'b0;
  logic             pll_locked = 1'b0;
  logic             sw_reset = 1'b0;
  logic             pll_rst;
  logic [NCHAN-1:0] chan_rstn;
  logic             ready;
  logic [7:0]       relock_count;
  logic [7:0]       kick_count;

  always #20 clkin = ~clkin;

  ulx3s_pll_reset_sequencer #(
    .NCHAN(NCHAN), .LOCK_STABLE(LOCK_STABLE), .STAGGER(STAGGER),
    .TIMEOUT(TIMEOUT), .KICK_LEN(KICK_LEN)
  ) dut (
    .clkin(clkin), .resetn(resetn), .pll_locked(pll_locked), .sw_reset(sw_reset),
    .pll_rst(pll_rst), .chan_rstn(chan_rstn), .ready(ready),
    .relock_count(relock_count), .kick_count(kick_count)
  );

  typedef struct {
    int               edge_n;
    logic             pll_rst;
    logic [NCHAN-1:0] chan;
    logic             ready;
    logic [7:0]       relock;
    logic [7:0]       kick;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  // Model: time-stamped phases (waiting / releasing / kicking) rather than counters.
  int   m_n, m_mode, m_win, m_run, m_rel, m_kick_at, m_relock, m_kicks;
  logic m_s1, m_s2;

  // Observation trackers (edge numbers of DUT output transitions).
  int   first_rise[NCHAN];
  int   first_ready;
  int   rst_rise_q[$];
  int   rst_fall_q[$];
  logic prev_rst;

  task automatic model_reset();
    m_n = 0; m_mode = M_WAIT; m_win = 0; m_run = 0; m_rel = 0; m_kick_at = 0;
    m_relock = 0; m_kicks = 0; m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic clear_trackers();
    for (int i = 0; i < NCHAN; i++) first_rise[i] = -1;
    first_ready = -1;
    rst_rise_q.delete();
    rst_fall_q.delete();
    prev_rst = 1'b0;
  endtask

  task automatic model_step();
    logic lk;
    exp_t e;
    int   k;
    lk = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    m_n++;
    case (m_mode)
      M_WAIT: begin
        if (m_n - m_win == TIMEOUT) begin
          m_mode = M_KICK;
          m_kick_at = m_n;
          m_kicks = (m_kicks < 255) ? m_kicks + 1 : 255;
        end else if (lk) begin
          m_run++;
          if (m_run == LOCK_STABLE + 1) begin
            m_mode = M_REL;
            m_rel = m_n;
          end
        end else begin
          m_run = 0;
        end
      end
      M_REL: begin
        if (!lk) begin
          m_mode = M_WAIT; m_win = m_n; m_run = 0;
          m_relock = (m_relock < 255) ? m_relock + 1 : 255;
        end else if (sw_reset) begin
          m_rel = m_n;
        end
      end
      default: begin
        if (m_n - m_kick_at == KICK_LEN) begin
          m_mode = M_WAIT; m_win = m_n; m_run = 0;
        end
      end
    endcase
    e.edge_n  = m_n;
    e.pll_rst = (m_mode == M_KICK);
    e.chan    = '0;
    e.ready   = 1'b0;
    if (m_mode == M_REL) begin
      k = m_n - m_rel;
      for (int i = 0; i < NCHAN; i++) e.chan[i] = (k >= (i + 1) * STAGGER);
      e.ready = (k >= NCHAN * STAGGER);
    end
    e.relock = 8'(m_relock);
    e.kick   = 8'(m_kicks);
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int need);
    total++;
    if (got != need) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d", name, got, need);
    end
  endtask

  task automatic cycle(input logic pl, input logic sw);
    pll_locked = pl;
    sw_reset   = sw;
    @(posedge clkin);
    model_step();
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"}, int'(pll_rst), 0);
    check({tag, "_chan"}, int'(chan_rstn), 0);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_relock"}, int'(relock_count), 0);
    check({tag, "_kick"}, int'(kick_count), 0);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #1;
    check_reset_values(tag);
    sb_q.delete();
    model_reset();
    clear_trackers();
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    resetn = 1'b1;
    #1;
  endtask

  always @(negedge clkin) begin
    if (resetn && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      total++;
      if (pll_rst !== mon_e.pll_rst || chan_rstn !== mon_e.chan || ready !== mon_e.ready ||
          relock_count !== mon_e.relock || kick_count !== mon_e.kick) begin
        bad++;
        $display("FAIL outputs@edge%0d got rst=%b chan=%b rdy=%b relock=%0d kick=%0d need rst=%b chan=%b rdy=%b relock=%0d kick=%0d",
                 mon_e.edge_n, pll_rst, chan_rstn, ready, relock_count, kick_count,
                 mon_e.pll_rst, mon_e.chan, mon_e.ready, mon_e.relock, mon_e.kick);
      end
      for (int i = 0; i < NCHAN; i++)
        if (chan_rstn[i] === 1'b1 && first_rise[i] < 0) first_rise[i] = mon_e.edge_n;
      if (ready === 1'b1 && first_ready < 0) first_ready = mon_e.edge_n;
      if (pll_rst === 1'b1 && prev_rst === 1'b0) rst_rise_q.push_back(mon_e.edge_n);
      if (pll_rst === 1'b0 && prev_rst === 1'b1) rst_fall_q.push_back(mon_e.edge_n);
      prev_rst = pll_rst;
    end
  end

  initial begin
    int hold;
    model_reset();
    clear_trackers();
    pll_locked = 1'b1;
    #5;
    check_reset_values("por");
    @(negedge clkin);
    resetn = 1'b1;
    #1;

    // Clean start: lock present from reset release.
    repeat (40) cycle(1'b1, 1'b0);
    for (int i = 0; i < NCHAN; i++)
      check($sformatf("clean_chan%0d_rise_edge", i), first_rise[i], 3 + LOCK_STABLE + (i + 1) * STAGGER);
    check("clean_ready_edge", first_ready, 35);
    check("clean_relock", int'(relock_count), 0);

    // Software restart pulse in RUN.
    cycle(1'b1, 1'b1);
    repeat (20) cycle(1'b1, 1'b0);

    // Lock loss in RUN, then recovery.
    repeat (3) cycle(1'b0, 1'b0);
    check("lockloss_relock", int'(relock_count), 1);
    repeat (45) cycle(1'b1, 1'b0);

    // Single-cycle glitch during the stability window.
    do_reset("glitch_rst");
    repeat (12) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (45) cycle(1'b1, 1'b0);
    check("glitch_relock", int'(relock_count), 0);
    check("glitch_ready_late", int'(first_ready > 35), 1);

    // Randomised lock glitches and software restarts.
    repeat (800) cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 29) == 0));

    // Timeout kicks with no lock at all.
    do_reset("timeout_rst");
    repeat (150) cycle(1'b0, 1'b0);
    check("kick1_rise", (rst_rise_q.size() > 0) ? rst_rise_q[0] : -1, TIMEOUT);
    check("kick1_fall", (rst_fall_q.size() > 0) ? rst_fall_q[0] : -1, TIMEOUT + KICK_LEN);
    check("kick2_rise", (rst_rise_q.size() > 1) ? rst_rise_q[1] : -1, 2 * TIMEOUT + KICK_LEN);
    check("kick_count2", int'(kick_count), 2);

    // Drive the kick counter into saturation.
    repeat (256 * (TIMEOUT + KICK_LEN)) cycle(1'b0, 1'b0);
    check("kick_saturated", int'(kick_count), 255);

    // Asynchronous reset in the middle of a kick.
    do_reset("prekick_rst");
    repeat (TIMEOUT + 3) cycle(1'b0, 1'b0);
    check("midkick_pll_rst_high", int'(pll_rst), 1);
    check("midkick_kick_count", int'(kick_count), 1);
    do_reset("midkick_async");

    // Drive the relock counter into saturation.
    for (int it = 0; it < 262; it++) begin
      hold = $urandom_range(28, 40);
      repeat (hold) cycle(1'b1, ($urandom_range(0, 15) == 0));
      repeat ($urandom_range(3, 5)) cycle(1'b0, 1'b0);
    end
    check("relock_saturated", int'(relock_count), 255);

    @(negedge clkin);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
